// File: rtl/deck_shuffler.sv
// deck_shuffler: owns the 52-card deck and shuffles it in place.
//
// A shuffle re-initialises the deck to identity and then runs PASSES passes of
// index 0..51. Each step swaps deck[i] with deck[j], where j is returned by the
// external next-address generator. After the shuffle, cards are dealt one per
// request.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Start      in   pulse; re-initialise and shuffle (ignored while Busy)
//   Deal_req   in   pulse; deal the next card (honoured only in READY)
//   Addr_j     in   swap index from the generator (combinational from Addr_i/Count)
//   Addr_i     out  current pass index to the generator
//   Count      out  free-running 12-bit counter to the generator
//   Busy       out  high through INIT and all shuffle cycles
//   Done       out  one-cycle pulse on the first READY cycle
//   Card_valid out  one-cycle pulse; Card holds a freshly dealt id
//   Card       out  dealt card id 0..51, held between pulses
//   Deck_empty out  all 52 cards dealt since the last shuffle

module deck_shuffler #(
    parameter int unsigned PASSES = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Deal_req,
    input  logic [5:0]  Addr_j,
    output logic [5:0]  Addr_i,
    output logic [11:0] Count,
    output logic        Busy,
    output logic        Done,
    output logic        Card_valid,
    output logic [5:0]  Card,
    output logic        Deck_empty
);

    localparam int unsigned NumCards = 52;
    localparam logic [5:0]  LastIdx  = 6'(NumCards - 1);
    localparam logic [2:0]  LastPass = 3'(PASSES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShAddr,
        StShSwap,
        StReady
    } state_e;

    state_e     state;
    logic [5:0] deck [NumCards];
    logic [5:0] j_reg;
    logic [5:0] deal_ptr;
    logic [2:0] pass;

    // Addr_i is the pass pointer itself, so the generator sees it registered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= StIdle;
            Count      <= '0;
            Addr_i     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Card_valid <= 1'b0;
            Card       <= '0;
            Deck_empty <= 1'b0;
            j_reg      <= '0;
            deal_ptr   <= '0;
            pass       <= '0;
            for (int k = 0; k < NumCards; k++) begin
                deck[k] <= 6'(k);
            end
        end else begin
            Count      <= Count + 12'd1;
            Done       <= 1'b0;
            Card_valid <= 1'b0;

            case (state)
                StIdle: begin
                    if (Start) begin
                        state <= StInit;
                        Busy  <= 1'b1;
                    end
                end

                StInit: begin
                    for (int k = 0; k < NumCards; k++) begin
                        deck[k] <= 6'(k);
                    end
                    Addr_i     <= '0;
                    pass       <= '0;
                    deal_ptr   <= '0;
                    Deck_empty <= 1'b0;
                    state      <= StShAddr;
                end

                StShAddr: begin
                    // Out-of-range indices degrade to a self-swap.
                    j_reg <= (Addr_j > LastIdx) ? Addr_i : Addr_j;
                    state <= StShSwap;
                end

                StShSwap: begin
                    // When j_reg == Addr_i both writes carry the same value.
                    deck[Addr_i] <= deck[j_reg];
                    deck[j_reg]  <= deck[Addr_i];
                    if (Addr_i == LastIdx) begin
                        Addr_i <= '0;
                        pass   <= pass + 3'd1;
                        if (pass == LastPass) begin
                            state <= StReady;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state <= StShAddr;
                        end
                    end else begin
                        Addr_i <= Addr_i + 6'd1;
                        state  <= StShAddr;
                    end
                end

                StReady: begin
                    // Start has priority over a same-cycle deal request.
                    if (Start) begin
                        state      <= StInit;
                        Busy       <= 1'b1;
                        deal_ptr   <= '0;
                        Deck_empty <= 1'b0;
                    end else if (Deal_req && !Deck_empty) begin
                        Card       <= deck[deal_ptr];
                        Card_valid <= 1'b1;
                        deal_ptr   <= deal_ptr + 6'd1;
                        if (deal_ptr == LastIdx) begin
                            Deck_empty <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
